// File: rtl/motion_map_arbiter.sv
// Double-buffered per-tile motion map with frame statistics, debounced alarm,
// and a round-robin arbiter sharing the single read port of the displayed bank.
module motion_map_arbiter #(
  parameter int unsigned NTILES       = 256,
  parameter int unsigned AW           = 8,
  parameter logic        VS_POL       = 1'b1,
  parameter int unsigned ALARM_MIN    = 4,
  parameter int unsigned ALARM_FRAMES = 2
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          s_pVSync,
  input  logic          vec_we,
  input  logic [AW-1:0] vec_addr,
  input  logic          motion_detected,
  input  logic          r0_req,
  input  logic [AW-1:0] r0_addr,
  input  logic          r1_req,
  input  logic [AW-1:0] r1_addr,
  output logic          r0_gnt,
  output logic          r0_data,
  output logic          r1_gnt,
  output logic          r1_data,
  output logic [8:0]    active_tiles,
  output logic          frame_done,
  output logic          alarm
);

  localparam int unsigned CW = 9;
  localparam int unsigned SW = 3;

  logic [NTILES-1:0] bank0;
  logic [NTILES-1:0] bank1;
  logic              sel;
  logic              vs_q;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     streak;
  logic              last_gnt;

  logic              boundary_c;
  logic [NTILES-1:0] w_bank_c;
  logic [NTILES-1:0] r_bank_c;
  logic              old_bit_c;
  logic [CW-1:0]     cnt_next_c;
  logic [SW-1:0]     streak_next_c;
  logic              elig0_c;
  logic              elig1_c;
  logic              grant0_c;
  logic              grant1_c;

  // Frame boundary, bank views, live count and arbitration decisions.
  always_comb begin
    boundary_c    = (s_pVSync == VS_POL) && (vs_q != VS_POL);
    w_bank_c      = sel ? bank1 : bank0;
    r_bank_c      = sel ? bank0 : bank1;
    old_bit_c     = w_bank_c[vec_addr];
    cnt_next_c    = cnt;
    streak_next_c = '0;
    if (vec_we && !old_bit_c && motion_detected) begin
      cnt_next_c = cnt + CW'(1);
    end else if (vec_we && old_bit_c && !motion_detected) begin
      cnt_next_c = cnt - CW'(1);
    end
    if (32'(cnt_next_c) >= ALARM_MIN) begin
      streak_next_c = (streak == '1) ? streak : streak + SW'(1);
    end
    elig0_c  = r0_req && !r0_gnt;
    elig1_c  = r1_req && !r1_gnt;
    // last_gnt==1 means port 1 won last, so port 0 takes a tie.
    grant0_c = elig0_c && (!elig1_c || last_gnt);
    grant1_c = elig1_c && !grant0_c;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      bank0        <= '0;
      bank1        <= '0;
      sel          <= 1'b0;
      vs_q         <= VS_POL;
      cnt          <= '0;
      streak       <= '0;
      active_tiles <= '0;
      frame_done   <= 1'b0;
      alarm        <= 1'b0;
      r0_gnt       <= 1'b0;
      r0_data      <= 1'b0;
      r1_gnt       <= 1'b0;
      r1_data      <= 1'b0;
      last_gnt     <= 1'b1;
    end else begin
      vs_q       <= s_pVSync;
      frame_done <= boundary_c;
      // Writes land in W; on a boundary the outgoing R is cleared to become the new W.
      if (vec_we) begin
        if (sel) bank1[vec_addr] <= motion_detected;
        else     bank0[vec_addr] <= motion_detected;
      end
      if (boundary_c) begin
        if (sel) bank0 <= '0;
        else     bank1 <= '0;
        sel          <= ~sel;
        active_tiles <= cnt_next_c;
        cnt          <= '0;
        streak       <= streak_next_c;
        alarm        <= (32'(streak_next_c) >= ALARM_FRAMES);
      end else begin
        cnt <= cnt_next_c;
      end
      r0_gnt  <= grant0_c;
      r0_data <= grant0_c ? r_bank_c[r0_addr] : 1'b0;
      r1_gnt  <= grant1_c;
      r1_data <= grant1_c ? r_bank_c[r1_addr] : 1'b0;
      if (grant0_c)      last_gnt <= 1'b0;
      else if (grant1_c) last_gnt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_motion_map_arbiter.sv
// Scoreboard bench for motion_map_arbiter: stimulus pushes expectations from a
// frame-level model, a negedge monitor pops and compares on frame_done / grants.
module tb_motion_map_arbiter;

  logic       pclk = 1'b0;
  logic       rst;
  logic       s_pVSync;
  logic       vec_we;
  logic [7:0] vec_addr;
  logic       motion_detected;
  logic       r0_req;
  logic [7:0] r0_addr;
  logic       r1_req;
  logic [7:0] r1_addr;
  logic       r0_gnt;
  logic       r0_data;
  logic       r1_gnt;
  logic       r1_data;
  logic [8:0] active_tiles;
  logic       frame_done;
  logic       alarm;

  motion_map_arbiter dut (
    .pclk(pclk), .rst(rst), .s_pVSync(s_pVSync), .vec_we(vec_we),
    .vec_addr(vec_addr), .motion_detected(motion_detected),
    .r0_req(r0_req), .r0_addr(r0_addr), .r1_req(r1_req), .r1_addr(r1_addr),
    .r0_gnt(r0_gnt), .r0_data(r0_data), .r1_gnt(r1_gnt), .r1_data(r1_data),
    .active_tiles(active_tiles), .frame_done(frame_done), .alarm(alarm)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int cnt;
    bit alm;
  } frame_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     mw[256];
  bit     mr[256];
  int     streak = 0;
  frame_t exp_frames[$];
  bit     exp_r0[$];
  bit     exp_r1[$];
  int     glog_port[$];
  int     glog_cyc[$];
  frame_t mf;
  bit     fd_prev = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every frame result and every grant against queued expectations.
  always @(negedge pclk) begin
    if (!rst) begin
      if (r0_gnt && r1_gnt) chk("dual_grant", 1, 0);
      if (frame_done) begin
        if (fd_prev) chk("frame_done_width", 2, 1);
        if (exp_frames.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          mf = exp_frames.pop_front();
          chk("active_tiles", int'(active_tiles), mf.cnt);
          chk("alarm", int'(alarm), int'(mf.alm));
        end
      end
      fd_prev = frame_done;
      if (r0_gnt) begin
        if (exp_r0.size() == 0) chk("unexpected_r0_gnt", 1, 0);
        else chk("r0_data", int'(r0_data), int'(exp_r0.pop_front()));
        glog_port.push_back(0);
        glog_cyc.push_back(cyc);
      end
      if (r1_gnt) begin
        if (exp_r1.size() == 0) chk("unexpected_r1_gnt", 1, 0);
        else chk("r1_data", int'(r1_data), int'(exp_r1.pop_front()));
        glog_port.push_back(1);
        glog_cyc.push_back(cyc);
      end
    end else begin
      fd_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wr(input int a, input bit m);
    vec_we = 1'b1;
    vec_addr = 8'(a);
    motion_detected = m;
    mw[a] = m;
    step();
    vec_we = 1'b0;
  endtask

  // Closed frame: count = moving tiles in the written map; written map becomes displayed.
  task automatic model_boundary();
    frame_t f;
    int c = 0;
    foreach (mw[i]) c += int'(mw[i]);
    streak = (c >= 4) ? ((streak >= 7) ? 7 : streak + 1) : 0;
    f.cnt = c;
    f.alm = (streak >= 2);
    exp_frames.push_back(f);
    mr = mw;
    foreach (mw[i]) mw[i] = 1'b0;
  endtask

  task automatic vsync_edge(input int hold);
    model_boundary();
    s_pVSync = 1'b1;
    repeat (hold) step();
    s_pVSync = 1'b0;
    step();
  endtask

  task automatic rd(input int p, input int a);
    bit got = 1'b0;
    if (p == 0) begin
      exp_r0.push_back(mr[a]);
      r0_req = 1'b1;
      r0_addr = 8'(a);
    end else begin
      exp_r1.push_back(mr[a]);
      r1_req = 1'b1;
      r1_addr = 8'(a);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if ((p == 0 && r0_gnt) || (p == 1 && r1_gnt)) begin
        got = 1'b1;
        break;
      end
    end
    if (p == 0) r0_req = 1'b0;
    else        r1_req = 1'b0;
    if (!got) chk("read_grant_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_r0_gnt"}, int'(r0_gnt), 0);
    chk({tag, "_r1_gnt"}, int'(r1_gnt), 0);
    chk({tag, "_r0_data"}, int'(r0_data), 0);
    chk({tag, "_r1_data"}, int'(r1_data), 0);
    chk({tag, "_active_tiles"}, int'(active_tiles), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    s_pVSync = 1'b0;
    vec_we = 1'b0;
    vec_addr = '0;
    motion_detected = 1'b0;
    r0_req = 1'b0;
    r0_addr = '0;
    r1_req = 1'b0;
    r1_addr = '0;
    repeat (3) @(posedge pclk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Both ports held: alternate one grant per cycle, r0 first.
    glog_port.delete();
    glog_cyc.delete();
    fork
      for (int i = 0; i < 6; i++) rd(0, int'($urandom_range(0, 255)));
      for (int i = 0; i < 6; i++) rd(1, int'($urandom_range(0, 255)));
    join
    step();
    chk("both_grant_count", glog_port.size(), 12);
    for (int i = 0; i < glog_port.size(); i++) begin
      chk("both_grant_order", glog_port[i], i % 2);
      if (i > 0) chk("both_grant_spacing", glog_cyc[i] - glog_cyc[i-1], 1);
    end

    // Single port held: one grant every other cycle.
    glog_port.delete();
    glog_cyc.delete();
    for (int i = 0; i < 4; i++) rd(0, i);
    step();
    chk("single_grant_count", glog_port.size(), 4);
    for (int i = 1; i < glog_cyc.size(); i++)
      chk("single_grant_spacing", glog_cyc[i] - glog_cyc[i-1], 2);

    // Right-half motion frame.
    for (int a = 0; a < 256; a++) wr(a, (a % 16) >= 8);
    vsync_edge(1);
    rd(0, 0);
    rd(1, 8);
    rd(0, 255);

    // Black frame; displayed map unchanged until its boundary.
    for (int a = 0; a < 256; a++) wr(a, 1'b0);
    rd(1, 8);
    vsync_edge(2);
    rd(0, 8);
    rd(1, 255);
    for (int i = 0; i < 4; i++) rd(i % 2, int'($urandom_range(0, 255)));

    // Rewrite the same tile repeatedly.
    wr(5, 1'b1);
    wr(5, 1'b1);
    wr(5, 1'b0);
    wr(5, 1'b1);
    vsync_edge(1);
    rd(0, 5);

    // Alarm debounce: counts 4, 4, 3.
    for (int f = 0; f < 3; f++) begin
      base = int'($urandom_range(16, 200));
      for (int k = 0; k < ((f == 2) ? 3 : 4); k++) wr(base + k, 1'b1);
      vsync_edge(1);
    end

    // Random frames with concurrent reads and held vsync.
    for (int f = 0; f < 4; f++) begin
      fork
        for (int k = 0; k < 40; k++) wr(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 5; k++) rd(0, int'($urandom_range(0, 255)));
        for (int k = 0; k < 5; k++) rd(1, int'($urandom_range(0, 255)));
      join
      vsync_edge(int'($urandom_range(1, 5)));
    end

    // Boundary collision: write and read of tile 7 on the boundary edge.
    wr(7, 1'b0);
    vsync_edge(1);
    wr(3, 1'b1);
    wr(9, 1'b1);
    mw[7] = 1'b1;
    exp_r1.push_back(mr[7]);
    model_boundary();
    s_pVSync = 1'b1;
    vec_we = 1'b1;
    vec_addr = 8'd7;
    motion_detected = 1'b1;
    r1_req = 1'b1;
    r1_addr = 8'd7;
    step();
    vec_we = 1'b0;
    s_pVSync = 1'b0;
    chk("collision_r1_gnt", int'(r1_gnt), 1);
    r1_req = 1'b0;
    step();
    rd(1, 7);

    // Reset mid-frame with a grant in flight.
    wr(20, 1'b1);
    wr(21, 1'b1);
    r0_req = 1'b1;
    r0_addr = 8'd7;
    step();
    rst = 1'b1;
    r0_req = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_r0.delete();
    exp_r1.delete();
    exp_frames.delete();
    foreach (mw[i]) begin
      mw[i] = 1'b0;
      mr[i] = 1'b0;
    end
    streak = 0;
    step();
    rst = 1'b0;
    step();
    rd(0, 7);
    rd(1, 20);
    vsync_edge(1);
    rd(0, 20);

    repeat (3) step();
    chk("frames_drained", exp_frames.size(), 0);
    chk("r0_drained", exp_r0.size(), 0);
    chk("r1_drained", exp_r1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
